// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the IF-stage fetch controller: widths, run-control
// state encoding and step-mode values.
package pc_fetch_ctrl_pkg;

  localparam int unsigned LenAddrDef  = 32;
  localparam int unsigned LenCountDef = 32;

  localparam logic StepModeCont   = 1'b0;
  localparam logic StepModeSingle = 1'b1;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStepWait = 2'd2,
    StHalted   = 2'd3
  } fetch_state_e;

  function automatic fetch_state_e start_state(input logic step_mode);
    return (step_mode == StepModeSingle) ? StStepWait : StRun;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Control and address bus between the pipeline/debug unit and the fetch controller.
interface pc_fetch_ctrl_if #(
  parameter int unsigned len_addr  = pc_fetch_ctrl_pkg::LenAddrDef,
  parameter int unsigned len_count = pc_fetch_ctrl_pkg::LenCountDef
) ();

  logic                 i_start;
  logic                 i_step_mode;
  logic                 i_step;
  logic                 i_stall;
  logic                 i_halt;
  logic                 i_branch_taken;
  logic [len_addr-1:0]  i_branch_target;
  logic                 i_jump;
  logic [len_addr-1:0]  i_jump_target;
  logic [len_addr-1:0]  i_adder_out;
  logic [len_addr-1:0]  o_pc;
  logic                 o_fetch_en;
  logic                 o_halted;
  logic [len_count-1:0] o_fetch_count;

  modport master (
    output i_start, i_step_mode, i_step, i_stall, i_halt, i_branch_taken,
           i_branch_target, i_jump, i_jump_target, i_adder_out,
    input  o_pc, o_fetch_en, o_halted, o_fetch_count
  );

  modport slave (
    input  i_start, i_step_mode, i_step, i_stall, i_halt, i_branch_taken,
           i_branch_target, i_jump, i_jump_target, i_adder_out,
    output o_pc, o_fetch_en, o_halted, o_fetch_count
  );

endinterface

// File: rtl/pc_fetch_ctrl_step_edge_detect.sv
// Rising-edge detector for the debug step request: one-cycle pulse per edge.
module pc_fetch_ctrl_step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_step,
  output logic o_pulse
);

  logic r_step_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= i_step;
    end
  end

  assign o_pulse = i_step & ~r_step_prev;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and fetch controller: run-control FSM, next-PC select
// (branch > jump > adder) and a count of PC advances since start.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned len_addr  = LenAddrDef,
  parameter int unsigned len_count = LenCountDef
) (
  input  logic              clk,
  input  logic              reset,
  pc_fetch_ctrl_if.slave    fetch_bus
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_next;
  logic [len_addr-1:0]  r_pc;
  logic [len_addr-1:0]  w_pc_next;
  logic [len_count-1:0] r_count;
  logic [len_count-1:0] w_count_next;
  logic                 w_step_pulse;
  logic                 w_active;
  logic                 w_redirect;
  logic                 w_advance;

  pc_fetch_ctrl_step_edge_detect u_step_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .i_step  (fetch_bus.i_step),
    .o_pulse (w_step_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_active     = (r_state == StRun) || ((r_state == StStepWait) && w_step_pulse);
    w_redirect   = fetch_bus.i_branch_taken | fetch_bus.i_jump;
    // A redirect must win over a stall or the redirected instruction is lost.
    w_advance    = w_active & (~fetch_bus.i_stall | w_redirect) & ~fetch_bus.i_halt;

    unique case (r_state)
      StIdle, StHalted: begin
        if (fetch_bus.i_start) begin
          w_state_next = start_state(fetch_bus.i_step_mode);
          w_pc_next    = '0;
          w_count_next = '0;
        end
      end
      StRun, StStepWait: begin
        if (w_active && fetch_bus.i_halt) begin
          w_state_next = StHalted;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_advance) begin
      if (fetch_bus.i_branch_taken) begin
        w_pc_next = fetch_bus.i_branch_target;
      end else if (fetch_bus.i_jump) begin
        w_pc_next = fetch_bus.i_jump_target;
      end else begin
        w_pc_next = fetch_bus.i_adder_out;
      end
      w_count_next = r_count + len_count'(1);
    end
  end

  assign fetch_bus.o_pc          = r_pc;
  assign fetch_bus.o_fetch_en    = w_advance;
  assign fetch_bus.o_halted      = (r_state == StHalted);
  assign fetch_bus.o_fetch_count = r_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the run-control rules.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MStep = 2;
  localparam int MHalt = 3;

  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_prev_step;

  pc_fetch_ctrl_if #(.len_addr(32), .len_count(32)) bus ();

  pc_fetch_ctrl #(.len_addr(32), .len_count(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_bus (bus)
  );

  always #5 clk = ~clk;

  // The PC adder downstream of o_pc.
  assign bus.i_adder_out = bus.o_pc + 32'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic m_fetch_en();
    logic step_edge;
    logic go;
    step_edge = bus.i_step && !m_prev_step;
    go = (m_mode == MRun) || (m_mode == MStep && step_edge);
    return go && (!bus.i_stall || bus.i_branch_taken || bus.i_jump) && !bus.i_halt;
  endfunction

  task automatic model_reset();
    m_mode      = MIdle;
    m_pc        = 32'd0;
    m_cnt       = 32'd0;
    m_prev_step = 1'b0;
  endtask

  // Predict the post-edge state from the current inputs, then clock.
  task automatic tick();
    int          n_mode;
    logic [31:0] n_pc;
    logic [31:0] n_cnt;
    logic        step_edge;
    logic        go;
    logic        n_prev;
    step_edge = bus.i_step && !m_prev_step;
    go        = (m_mode == MRun) || (m_mode == MStep && step_edge);
    n_mode = m_mode;
    n_pc   = m_pc;
    n_cnt  = m_cnt;
    n_prev = bus.i_step;
    if ((m_mode == MIdle || m_mode == MHalt) && bus.i_start) begin
      n_pc   = 32'd0;
      n_cnt  = 32'd0;
      n_mode = bus.i_step_mode ? MStep : MRun;
    end else if (go && bus.i_halt) begin
      n_mode = MHalt;
    end else if (m_fetch_en()) begin
      if (bus.i_branch_taken)  n_pc = bus.i_branch_target;
      else if (bus.i_jump)     n_pc = bus.i_jump_target;
      else                     n_pc = m_pc + 32'd1;
      n_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    m_mode      = n_mode;
    m_pc        = n_pc;
    m_cnt       = n_cnt;
    m_prev_step = n_prev;
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_start         = 1'b0;
    bus.i_step_mode     = 1'b0;
    bus.i_step          = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_halt          = 1'b0;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = 32'd0;
    bus.i_jump          = 1'b0;
    bus.i_jump_target   = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (bus.o_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0h want 0", bus.o_fetch_count); end
    n_checks++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.o_halted); end
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_en: got %b want 0", bus.o_fetch_en); end
    repeat (3) tick();
    n_checks++; if (bus.o_pc !== 32'd0) begin n_fail++; $display("FAIL idle_hold_pc: got %0h want 0", bus.o_pc); end
  endtask

  task automatic test_continuous();
    do_reset();
    bus.i_start = 1'b1;
    bus.i_step_mode = 1'b0;
    #1;
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL start_cycle_fetch_en: got %b want 0", bus.o_fetch_en); end
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.o_pc !== 32'(i)) begin n_fail++; $display("FAIL run_pc[%0d]: got %0h want %0h", i, bus.o_pc, i); end
      n_checks++; if (bus.o_fetch_en !== 1'b1) begin n_fail++; $display("FAIL run_fetch_en[%0d]: got %b want 1", i, bus.o_fetch_en); end
      tick();
    end
    n_checks++; if (bus.o_pc !== 32'd5) begin n_fail++; $display("FAIL run_pc_end: got %0h want 5", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd5) begin n_fail++; $display("FAIL run_count: got %0d want 5", bus.o_fetch_count); end
  endtask

  task automatic test_stall_redirect();
    repeat (2) tick();
    n_checks++; if (bus.o_pc !== 32'd7) begin n_fail++; $display("FAIL pre_stall_pc: got %0h want 7", bus.o_pc); end
    bus.i_stall = 1'b1;
    #1;
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL stall_fetch_en: got %b want 0", bus.o_fetch_en); end
    repeat (2) tick();
    n_checks++; if (bus.o_pc !== 32'd7) begin n_fail++; $display("FAIL stall_pc: got %0h want 7", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd7) begin n_fail++; $display("FAIL stall_count: got %0d want 7", bus.o_fetch_count); end
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h40;
    #1;
    n_checks++; if (bus.o_fetch_en !== 1'b1) begin n_fail++; $display("FAIL redirect_fetch_en: got %b want 1", bus.o_fetch_en); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (bus.o_pc !== 32'h40) begin n_fail++; $display("FAIL stall_redirect_pc: got %0h want 40", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd8) begin n_fail++; $display("FAIL redirect_count: got %0d want 8", bus.o_fetch_count); end
  endtask

  task automatic test_priority();
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h20;
    bus.i_jump          = 1'b1;
    bus.i_jump_target   = 32'h80;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (bus.o_pc !== 32'h20) begin n_fail++; $display("FAIL prio_branch_pc: got %0h want 20", bus.o_pc); end
    bus.i_jump        = 1'b1;
    bus.i_jump_target = 32'h80;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (bus.o_pc !== 32'h80) begin n_fail++; $display("FAIL jump_pc: got %0h want 80", bus.o_pc); end
  endtask

  task automatic test_halt();
    logic [31:0] cnt_before;
    bus.i_jump        = 1'b1;
    bus.i_jump_target = 32'd9;
    tick();
    clear_inputs();
    cnt_before = m_cnt;
    bus.i_halt = 1'b1;
    #1;
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL halt_cycle_fetch_en: got %b want 0", bus.o_fetch_en); end
    tick();
    bus.i_halt = 1'b0;
    #1;
    n_checks++; if (bus.o_pc !== 32'd9) begin n_fail++; $display("FAIL halt_pc: got %0h want 9", bus.o_pc); end
    n_checks++; if (bus.o_halted !== 1'b1) begin n_fail++; $display("FAIL halted: got %b want 1", bus.o_halted); end
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL halted_fetch_en: got %b want 0", bus.o_fetch_en); end
    n_checks++; if (bus.o_fetch_count !== cnt_before) begin n_fail++; $display("FAIL halt_count: got %0d want %0d", bus.o_fetch_count, cnt_before); end
    repeat (2) tick();
    n_checks++; if (bus.o_pc !== 32'd9) begin n_fail++; $display("FAIL halted_hold_pc: got %0h want 9", bus.o_pc); end
    bus.i_start     = 1'b1;
    bus.i_step_mode = 1'b0;
    tick();
    bus.i_start = 1'b0;
    #1;
    n_checks++; if (bus.o_pc !== 32'd0) begin n_fail++; $display("FAIL restart_pc: got %0h want 0", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd0) begin n_fail++; $display("FAIL restart_count: got %0d want 0", bus.o_fetch_count); end
    n_checks++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL restart_halted: got %b want 0", bus.o_halted); end
    n_checks++; if (bus.o_fetch_en !== 1'b1) begin n_fail++; $display("FAIL restart_fetch_en: got %b want 1", bus.o_fetch_en); end
  endtask

  task automatic test_single_step();
    do_reset();
    bus.i_start     = 1'b1;
    bus.i_step_mode = 1'b1;
    tick();
    bus.i_start = 1'b0;
    #1;
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL step_wait_fetch_en: got %b want 0", bus.o_fetch_en); end
    bus.i_step = 1'b1;
    repeat (4) tick();
    n_checks++; if (bus.o_pc !== 32'd1) begin n_fail++; $display("FAIL step_held_pc: got %0h want 1", bus.o_pc); end
    bus.i_step = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      tick();
    end
    n_checks++; if (bus.o_pc !== 32'd4) begin n_fail++; $display("FAIL step_pulses_pc: got %0h want 4", bus.o_pc); end
    n_checks++; if (bus.o_fetch_count !== 32'd4) begin n_fail++; $display("FAIL step_pulses_count: got %0d want 4", bus.o_fetch_count); end
    // An edge landing on a stall is used up without advancing.
    bus.i_step  = 1'b1;
    bus.i_stall = 1'b1;
    tick();
    bus.i_stall = 1'b0;
    tick();
    bus.i_step = 1'b0;
    tick();
    n_checks++; if (bus.o_pc !== 32'd4) begin n_fail++; $display("FAIL step_stall_pc: got %0h want 4", bus.o_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_start = 1'b1;
    tick();
    bus.i_start       = 1'b0;
    bus.i_jump        = 1'b1;
    bus.i_jump_target = 32'h33;
    tick();
    clear_inputs();
    #2;
    n_checks++; if (bus.o_pc !== 32'h33) begin n_fail++; $display("FAIL pre_reset_pc: got %0h want 33", bus.o_pc); end
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus.o_pc !== 32'd0) begin n_fail++; $display("FAIL async_reset_pc: got %0h want 0", bus.o_pc); end
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL async_reset_fetch_en: got %b want 0", bus.o_fetch_en); end
    n_checks++; if (bus.o_fetch_count !== 32'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d want 0", bus.o_fetch_count); end
    #1;
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.o_pc !== 32'd0) begin n_fail++; $display("FAIL post_reset_pc: got %0h want 0", bus.o_pc); end
    n_checks++; if (bus.o_fetch_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_fetch_en: got %b want 0", bus.o_fetch_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.i_start         = ($urandom_range(0, 9) == 0);
      bus.i_step_mode     = 1'($urandom_range(0, 1));
      bus.i_step          = 1'($urandom_range(0, 1));
      bus.i_stall         = ($urandom_range(0, 9) < 3);
      bus.i_halt          = ($urandom_range(0, 29) == 0);
      bus.i_branch_taken  = ($urandom_range(0, 9) == 0);
      bus.i_branch_target = $urandom;
      bus.i_jump          = ($urandom_range(0, 9) == 0);
      bus.i_jump_target   = $urandom;
      #1;
      n_checks++; if (bus.o_pc !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %0h want %0h", c, bus.o_pc, m_pc); end
      n_checks++; if (bus.o_fetch_count !== m_cnt) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, bus.o_fetch_count, m_cnt); end
      n_checks++; if (bus.o_halted !== (m_mode == MHalt)) begin n_fail++; $display("FAIL rand_halted[%0d]: got %b want %b", c, bus.o_halted, m_mode == MHalt); end
      n_checks++; if (bus.o_fetch_en !== m_fetch_en()) begin n_fail++; $display("FAIL rand_fetch_en[%0d]: got %b want %b", c, bus.o_fetch_en, m_fetch_en()); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_continuous();
    test_stall_redirect();
    test_priority();
    test_halt();
    test_single_step();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
